// File: rtl/alu_regs.sv
// alu_regs: execute stage of the 8-bit datapath.
// Holds working registers A and B and runs a single-cycle ALU on A and b_in.
// MUL is an 8-step iterative shift-add. Its operands are captured when it starts.
module alu_regs (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] b_in,
    input  logic [2:0] op,
    input  logic       start,
    input  logic       la,
    input  logic       lb,
    output logic [7:0] reg_a,
    output logic [7:0] reg_b,
    output logic [7:0] result,
    output logic       z,
    output logic       n,
    output logic       c,
    output logic       v,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state_q;
    logic [7:0]  reg_a_q, reg_b_q, result_q;
    logic        z_q, n_q, c_q, v_q, busy_q, done_q;
    logic [15:0] mcand_q, acc_q;
    logic [7:0]  mplr_q;
    logic [2:0]  cnt_q;
    logic        la_q, lb_q;

    logic [7:0]  alu_res_d;
    logic        alu_c_d, alu_v_d;
    logic [8:0]  sum9;
    logic [15:0] acc_d;

    // Single-cycle ALU on the live A register and the muxed second operand
    always_comb begin
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        sum9      = '0;
        case (op)
            OP_ADD: begin
                sum9      = {1'b0, reg_a_q} + {1'b0, b_in};
                alu_res_d = sum9[7:0];
                alu_c_d   = sum9[8];
                alu_v_d   = (reg_a_q[7] == b_in[7]) && (alu_res_d[7] != reg_a_q[7]);
            end
            OP_SUB: begin
                // bit 8 of the 9-bit difference is the borrow (A < B unsigned)
                sum9      = {1'b0, reg_a_q} - {1'b0, b_in};
                alu_res_d = sum9[7:0];
                alu_c_d   = sum9[8];
                alu_v_d   = (reg_a_q[7] != b_in[7]) && (alu_res_d[7] != reg_a_q[7]);
            end
            OP_AND: alu_res_d = reg_a_q & b_in;
            OP_OR:  alu_res_d = reg_a_q | b_in;
            OP_XOR: alu_res_d = reg_a_q ^ b_in;
            OP_NOT: alu_res_d = ~reg_a_q;
            OP_SHL: begin
                alu_res_d = {reg_a_q[6:0], 1'b0};
                alu_c_d   = reg_a_q[7];
            end
            default: ;
        endcase
    end

    // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        acc_d = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Control FSM plus all architectural state; outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            la_q     <= 1'b0;
            lb_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand_q <= {8'h00, reg_a_q};
                            mplr_q  <= b_in;
                            la_q    <= la;
                            lb_q    <= lb;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= MUL;
                        end else begin
                            result_q <= alu_res_d;
                            z_q      <= (alu_res_d == 8'h00);
                            n_q      <= alu_res_d[7];
                            c_q      <= alu_c_d;
                            v_q      <= alu_v_d;
                            done_q   <= 1'b1;
                            if (la) reg_a_q <= alu_res_d;
                            if (lb) reg_b_q <= alu_res_d;
                        end
                    end
                end
                MUL: begin
                    acc_q   <= acc_d;
                    mcand_q <= {mcand_q[14:0], 1'b0};
                    mplr_q  <= {1'b0, mplr_q[7:1]};
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_q <= acc_d[7:0];
                        z_q      <= (acc_d[7:0] == 8'h00);
                        n_q      <= acc_d[7];
                        c_q      <= |acc_d[15:8];
                        v_q      <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        if (la_q) reg_a_q <= acc_d[7:0];
                        if (lb_q) reg_b_q <= acc_d[7:0];
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_a  = reg_a_q;
    assign reg_b  = reg_b_q;
    assign result = result_q;
    assign z      = z_q;
    assign n      = n_q;
    assign c      = c_q;
    assign v      = v_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule
